// File: rtl/gp_cmd_sequencer.sv
// Command-execution stage: fetches 64-bit commands from cmd_buffer and runs them as master bus transactions.
// Optional POLL retry bound is enabled by defining GP_POLL_TIMEOUT_EN.
module gp_cmd_sequencer #(
    parameter int CMD_WIDTH        = 64,
    parameter int DATA_WIDTH       = 32,
    parameter int ADDR_WIDTH       = 32,
    parameter int TRANS_ADDR_WIDTH = 8,
    parameter int POLL_TIMEOUT     = 1024
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [TRANS_ADDR_WIDTH-1:0] start_addr,
    output logic                        busy,
    output logic                        done,
    output logic                        err,
    output logic                        cmd_rd_en,
    output logic [TRANS_ADDR_WIDTH-1:0] cmd_addr,
    input  logic                        cmd_rd_valid,
    input  logic [CMD_WIDTH-1:0]        cmd_out,
    output logic                        mst_o_valid,
    output logic [ADDR_WIDTH-1:0]       mst_o_addr,
    output logic [DATA_WIDTH-1:0]       mst_o_wr_data,
    output logic                        mst_o_rd0_wr1,
    input  logic                        mst_i_ready,
    input  logic                        mst_i_rd_valid,
    input  logic [DATA_WIDTH-1:0]       mst_i_rd_data
);

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_POLL  = 2'b01;
    localparam logic [1:0] OP_WAIT  = 2'b10;
    localparam logic [1:0] OP_END   = 2'b11;

`ifdef GP_POLL_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif
    localparam logic [15:0] POLL_LIMIT = 16'(POLL_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_REQ, S_RDWAIT, S_WAITCNT, S_NEXT
    } state_t;

    state_t                        r_state, w_state_next;
    logic [TRANS_ADDR_WIDTH-1:0]   r_ptr;
    logic [1:0]                    r_op;
    logic [ADDR_WIDTH-1:0]         r_addr;
    logic [DATA_WIDTH-1:0]         r_data, r_cnt, r_rd_data;
    logic                          r_wr, r_done, r_err, r_rd_pend;
    logic [15:0]                   r_attempts;

    logic [1:0]                    w_op;
    logic [ADDR_WIDTH-1:0]         w_cmd_addr;
    logic [DATA_WIDTH-1:0]         w_cmd_data, w_rd_data;
    logic                          w_accept, w_rd_valid, w_match, w_timeout;
    logic                          w_ptr_last, w_set_err, w_done_next;

    assign w_op       = cmd_out[CMD_WIDTH-1 -: 2];
    assign w_cmd_addr = {cmd_out[CMD_WIDTH-3:DATA_WIDTH], 2'b00};
    assign w_cmd_data = cmd_out[DATA_WIDTH-1:0];
    assign w_accept   = (r_state == S_IDLE) && start;
    // Read data that arrived together with ready is held in r_rd_data until RDWAIT consumes it.
    assign w_rd_valid = r_rd_pend || mst_i_rd_valid;
    assign w_rd_data  = r_rd_pend ? r_rd_data : mst_i_rd_data;
    assign w_match    = (w_rd_data == r_data);
    assign w_timeout  = TIMEOUT_EN && (r_attempts == POLL_LIMIT);
    assign w_ptr_last = &r_ptr[TRANS_ADDR_WIDTH-1:1];

    always_comb begin
        w_state_next = r_state;
        w_set_err    = 1'b0;
        w_done_next  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (start_addr[0]) w_set_err = 1'b1;
                    else               w_state_next = S_FETCH;
                end
            end
            S_FETCH:  w_state_next = S_DECODE;
            S_DECODE: begin
                if (!cmd_rd_valid) begin
                    w_set_err    = 1'b1;
                    w_state_next = S_IDLE;
                end else begin
                    case (w_op)
                        OP_WRITE, OP_POLL: w_state_next = S_REQ;
                        OP_WAIT: w_state_next = (w_cmd_data == '0) ? S_NEXT : S_WAITCNT;
                        default: begin
                            w_done_next  = 1'b1;
                            w_state_next = S_IDLE;
                        end
                    endcase
                end
            end
            S_REQ: begin
                if (mst_i_ready) w_state_next = (r_op == OP_POLL) ? S_RDWAIT : S_NEXT;
            end
            S_RDWAIT: begin
                if (w_rd_valid) begin
                    if (w_match) begin
                        w_state_next = S_NEXT;
                    end else if (w_timeout) begin
                        w_set_err    = 1'b1;
                        w_state_next = S_IDLE;
                    end else begin
                        w_state_next = S_REQ;
                    end
                end
            end
            S_WAITCNT: begin
                if (r_cnt <= DATA_WIDTH'(1)) w_state_next = S_NEXT;
            end
            S_NEXT: begin
                // The last even word has no successor; never wrap the fetch back to 0.
                if (w_ptr_last) begin
                    w_set_err    = 1'b1;
                    w_state_next = S_IDLE;
                end else begin
                    w_state_next = S_FETCH;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_op       <= OP_WRITE;
            r_addr     <= '0;
            r_data     <= '0;
            r_cnt      <= '0;
            r_rd_data  <= '0;
            r_wr       <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_rd_pend  <= 1'b0;
            r_attempts <= '0;
        end else begin
            r_state <= w_state_next;
            r_done  <= w_done_next;

            if (w_accept)       r_err <= start_addr[0];
            else if (w_set_err) r_err <= 1'b1;

            if (w_accept && !start_addr[0])
                r_ptr <= start_addr;
            else if (r_state == S_NEXT && !w_ptr_last)
                r_ptr <= r_ptr + TRANS_ADDR_WIDTH'(2);

            if (r_state == S_DECODE && cmd_rd_valid) begin
                r_op       <= w_op;
                r_addr     <= w_cmd_addr;
                r_data     <= w_cmd_data;
                r_cnt      <= w_cmd_data;
                r_wr       <= (w_op == OP_WRITE);
                r_attempts <= '0;
            end else if (r_state == S_WAITCNT) begin
                r_cnt <= r_cnt - DATA_WIDTH'(1);
            end

            if (r_state == S_REQ && mst_i_ready && mst_i_rd_valid && r_op == OP_POLL) begin
                r_rd_pend <= 1'b1;
                r_rd_data <= mst_i_rd_data;
            end else if (r_state == S_RDWAIT) begin
                r_rd_pend <= 1'b0;
            end

            if (r_state == S_RDWAIT && w_rd_valid && !w_match)
                r_attempts <= r_attempts + 16'd1;
        end
    end

    assign busy          = (r_state != S_IDLE);
    assign done          = r_done;
    assign err           = r_err;
    assign cmd_rd_en     = (r_state == S_FETCH);
    assign cmd_addr      = r_ptr;
    assign mst_o_valid   = (r_state == S_REQ);
    assign mst_o_addr    = r_addr;
    assign mst_o_wr_data = r_data;
    assign mst_o_rd0_wr1 = r_wr;

endmodule
